// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-Lite responder that turns each accepted transfer into a single-beat
// valid/ready request on a simple backend port.
//
// Ports:
//   ahb_clk_in, ahb_rstn_in   clock, asynchronous active-low reset
//   ahb_sel_in .. ahb_ready_in  AHB address/data phase inputs (HSEL, HADDR, HTRANS, HWRITE,
//                               HSIZE, HBURST (ignored), HWDATA, HREADY)
//   ahb_readyout_out, ahb_resp_out, ahb_rdata_out   HREADYOUT, HRESP, HRDATA
//   other_valid_out, other_addr_out, other_write_out, other_size_out, other_wdata_out
//                               backend request (fields held stable while valid & !ready)
//   other_ready_in, other_error_in, other_rdata_in   backend completion, qualified by ready
//
// Illegal transfers (size wider than the bus, misaligned, outside the decoded window) and
// backend errors produce the two-cycle AHB ERROR response.
//
// Optional macro AHB_SLV_TIMEOUT_EN: abort a data phase with ERROR after SLV_WAIT_TIMEOUT
// backend wait cycles. Without it the data phase waits indefinitely.
module ahb_slave_if #(
    parameter int unsigned                  AHB_ADDR_WIDTH   = 32,
    parameter int unsigned                  AHB_DATA_WIDTH   = 32,
    parameter logic [AHB_ADDR_WIDTH-1:0]    SLV_BASE_ADDR    = '0,
    parameter logic [AHB_ADDR_WIDTH:0]      SLV_ADDR_SIZE    = (AHB_ADDR_WIDTH+1)'(4096),
    parameter int unsigned                  SLV_WAIT_TIMEOUT = 8
) (
    input  logic                      ahb_clk_in,
    input  logic                      ahb_rstn_in,
    input  logic                      ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
    input  logic [1:0]                ahb_trans_in,
    input  logic                      ahb_write_in,
    input  logic [2:0]                ahb_size_in,
    input  logic [2:0]                ahb_burst_in,
    input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
    input  logic                      ahb_ready_in,
    output logic                      ahb_readyout_out,
    output logic                      ahb_resp_out,
    output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
    output logic                      other_valid_out,
    output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
    output logic                      other_write_out,
    output logic [2:0]                other_size_out,
    output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
    input  logic                      other_ready_in,
    input  logic                      other_error_in,
    input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in
);

    typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

    state_e                    state_q, state_d;
    logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic [2:0]                size_q, size_d;

    // Burst type is irrelevant (every beat is a single); HTRANS[0] only separates SEQ/NONSEQ.
    logic unused_inputs;
    assign unused_inputs = ^{ahb_burst_in, ahb_trans_in[0]};

    logic accept;
    assign accept = ahb_sel_in & ahb_ready_in & ahb_trans_in[1];

    // Legality checks on the current address phase.
    logic [31:0]               size_bits;
    logic [AHB_ADDR_WIDTH-1:0] align_mask;
    logic [AHB_ADDR_WIDTH:0]   win_off;
    logic                      legal;

    assign size_bits  = 32'd8 << ahb_size_in;
    assign align_mask = (AHB_ADDR_WIDTH'(1) << ahb_size_in) - AHB_ADDR_WIDTH'(1);
    // Extra bit catches addresses below the base (borrow) without a constant compare.
    assign win_off    = {1'b0, ahb_addr_in} - {1'b0, SLV_BASE_ADDR};
    assign legal      = (size_bits <= AHB_DATA_WIDTH)
                      && ((ahb_addr_in & align_mask) == '0)
                      && !win_off[AHB_ADDR_WIDTH]
                      && (win_off < SLV_ADDR_SIZE);

    logic timeout;

`ifdef AHB_SLV_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(SLV_WAIT_TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Leaving DATA or completing a beat resets the count, so every DATA entry starts at 0.
    assign cnt_d   = (state_q == StData && !other_ready_in) ? cnt_q + 1'b1 : '0;
    assign timeout = (state_q == StData) && !other_ready_in
                   && (cnt_q == CntW'(SLV_WAIT_TIMEOUT - 1));

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unsigned unused_timeout = SLV_WAIT_TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_comb begin
        logic take;
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: take = accept;
            StData: begin
                if (timeout) begin
                    state_d = StErr1;
                end else if (other_ready_in) begin
                    if (other_error_in) begin
                        state_d = StErr1;
                    end else begin
                        state_d = StIdle;
                        take    = accept;
                    end
                end
            end
            StErr1: state_d = StErr2;
            StErr2: begin
                // The master cannot cancel an address phase issued during ERR2.
                state_d = StIdle;
                take    = accept;
            end
            default: state_d = StIdle;
        endcase
        if (take) begin
            state_d = legal ? StData : StErr1;
            addr_d  = ahb_addr_in;
            write_d = ahb_write_in;
            size_d  = ahb_size_in;
        end
    end

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        ahb_readyout_out = 1'b1;
        ahb_resp_out     = 1'b0;
        ahb_rdata_out    = '0;
        other_valid_out  = 1'b0;
        unique case (state_q)
            StIdle: ;
            StData: begin
                other_valid_out  = 1'b1;
                ahb_readyout_out = other_ready_in & ~other_error_in;
                if (other_ready_in && !write_q) begin
                    ahb_rdata_out = other_rdata_in;
                end
            end
            StErr1: begin
                ahb_readyout_out = 1'b0;
                ahb_resp_out     = 1'b1;
            end
            StErr2: ahb_resp_out = 1'b1;
            default: ;
        endcase
    end

    assign other_addr_out  = addr_q;
    assign other_write_out = write_q;
    assign other_size_out  = size_q;
    // The master holds HWDATA through wait states, so it can be forwarded unregistered.
    assign other_wdata_out = ahb_wdata_in;

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB-Lite responder: accepts AHB address and data phases from the bus, then presents each transfer as one single-beat request on a simple valid/ready backend port (other_*).
- Sits between the AHB interconnect and a register file or memory controller.
- Checks transfer legality (size, alignment, address window) and returns the two-cycle AHB ERROR response on failure or on a backend error.

Parameters:
AHB_ADDR_WIDTH, 32, address bus width
AHB_DATA_WIDTH, 32, data bus width (32 or 64)
SLV_BASE_ADDR, 0, first byte address decoded by this slave
SLV_ADDR_SIZE, 4096, byte size of the decoded window (power of 2)
SLV_WAIT_TIMEOUT, 8, backend wait limit in cycles (used only with the optional feature)

Ports:
ahb_clk_in  in  1  clock
ahb_rstn_in  in  1  reset
ahb_sel_in  in  1  HSEL
ahb_addr_in  in  AHB_ADDR_WIDTH  HADDR
ahb_trans_in  in  2  HTRANS: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
ahb_write_in  in  1  HWRITE
ahb_size_in  in  3  HSIZE
ahb_burst_in  in  3  HBURST (ignored; every beat is handled as a single)
ahb_wdata_in  in  AHB_DATA_WIDTH  HWDATA
ahb_ready_in  in  1  HREADY (bus-level)
ahb_readyout_out  out  1  HREADYOUT
ahb_resp_out  out  1  HRESP: 0 OKAY, 1 ERROR
ahb_rdata_out  out  AHB_DATA_WIDTH  HRDATA
other_valid_out  out  1  backend request valid
other_addr_out  out  AHB_ADDR_WIDTH  request address (absolute)
other_write_out  out  1  request direction
other_size_out  out  3  request size
other_wdata_out  out  AHB_DATA_WIDTH  write data
other_ready_in  in  1  backend done
other_error_in  in  1  backend error; qualified by other_ready_in
other_rdata_in  in  AHB_DATA_WIDTH  read data; qualified by other_ready_in

Behaviour:
- Reset: ahb_rstn_in, asynchronous, active-low. Clock: ahb_clk_in. All state is sampled on the posedge.
- Reset values:
  - State = IDLE.
  - ahb_readyout_out = 1, ahb_resp_out = 0, ahb_rdata_out = 0.
  - other_valid_out = 0, other_write_out = 0, other_size_out = 0, other_addr_out = 0.
- States: IDLE, DATA, ERR1, ERR2.
- Address-phase accept: ahb_sel_in & ahb_ready_in & ahb_trans_in[1]. On accept, register addr, write and size.
- Legality checks on accept:
  - Size legal: (8 << size) <= AHB_DATA_WIDTH.
  - Aligned: addr & ((1 << size) - 1) == 0.
  - In window: SLV_BASE_ADDR <= addr < SLV_BASE_ADDR + SLV_ADDR_SIZE.
  - Any check failing -> ERR1. All checks passing -> DATA.
- IDLE or BUSY with sel, or no sel: no backend access. Readyout = 1, resp = 0, zero wait states. State stays IDLE unless an accept occurs.
- DATA:
  - other_valid_out = 1 with the registered addr/write/size.
  - other_wdata_out = ahb_wdata_in, combinational pass-through (the master holds it during wait states).
  - Readyout = other_ready_in & !other_error_in.
  - ahb_rdata_out = other_rdata_in when other_ready_in & !write, else 0.
- DATA exit:
  - other_ready_in & other_error_in -> ERR1; readyout = 0 this cycle.
  - other_ready_in & !other_error_in -> transfer completes. A new accept in the same cycle (back-to-back pipelining) -> DATA or ERR1 per checks, else IDLE.
- Minimum latency: a zero-wait backend (ready asserted in the first DATA cycle) completes the data phase in 1 cycle.
- ERR1: readyout = 0, resp = 1, other_valid_out = 0. Always -> ERR2.
- ERR2: readyout = 1, resp = 1.
  - Accept in ERR2 is honoured (master may not cancel) -> DATA or ERR1.
  - Otherwise -> IDLE.
- Backend rule: other_valid_out stays high until other_ready_in. Request fields never change while valid & !ready.
- other_ready_in is ignored outside DATA.
- Reset mid-transfer: asynchronous return to IDLE with reset values. No backend completion is expected afterwards.
- ahb_resp_out = 0 in IDLE and DATA.

Optional Feature:
- AHB_SLV_TIMEOUT_EN defined:
  - A counter of width $clog2(SLV_WAIT_TIMEOUT+1) clears on entry to DATA and increments each DATA cycle with !other_ready_in.
  - When it reaches SLV_WAIT_TIMEOUT -> ERR1; other_valid_out drops the next cycle.
  - A late other_ready_in is ignored.
- AHB_SLV_TIMEOUT_EN undefined: no counter; DATA waits indefinitely.

Test Plan:
1. Single write, addr 0x10, size 2, data 0xA5A5_0001, backend ready in the first DATA cycle -> other_valid 1 cycle with addr 0x10, write=1; readyout never low; resp 0.
2. Read, addr 0x24, backend ready after 3 cycles with rdata 0x1234_5678 -> readyout low 3 cycles, then high with rdata 0x1234_5678, resp 0.
3. Back-to-back NONSEQ writes to 0x0, 0x4, 0x8, zero-wait backend -> three consecutive valid cycles, addresses in order, readyout continuously 1.
4. Misaligned read, addr 0x2, size 2 (then also size 3 on a 32-bit bus, and addr SLV_BASE_ADDR+SLV_ADDR_SIZE) -> no backend valid; readyout 0,1 with resp 1,1.
5. Backend asserts ready+error on a write to 0x40 -> ERR1 (readyout 0, resp 1) then ERR2 (readyout 1, resp 1), then IDLE with resp 0.
6. With AHB_SLV_TIMEOUT_EN and SLV_WAIT_TIMEOUT=8, backend never ready -> after 8 DATA cycles, 2-cycle ERROR; assert reset during DATA in a separate run -> readyout 1, valid 0 immediately.
